// File: rtl/idecode_sb.sv
// Instruction-decode stage: field split, operand read with writeback forwarding,
// immediate expansion and a per-register reservation scoreboard for RAW/WAW stalls.
module idecode_sb #(
    parameter int WORD  = 32,
    parameter int ADDR  = 32,
    parameter int NREG  = 8,
    parameter int W_RD  = $clog2(NREG),
    parameter int W_OPC = 5,
    parameter int W_IMM = 8,
    parameter logic [2**W_OPC-1:0] WB_MASK    = {(2**W_OPC){1'b0}},
    parameter logic [2**W_OPC-1:0] RDSRC_MASK = {(2**W_OPC){1'b0}},
    parameter logic [2**W_OPC-1:0] SEXT_MASK  = {(2**W_OPC){1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [WORD-1:0]  inst_i,
    input  logic [ADDR-1:0]  origaddr_i,
    input  logic             flush_i,
    output logic [W_RD-1:0]  rd_name_o,
    output logic [W_RD-1:0]  rs_name_o,
    input  logic [WORD-1:0]  rd_data_i,
    input  logic [WORD-1:0]  rs_data_i,
    input  logic             wb_v_i,
    input  logic [W_RD-1:0]  wb_name_i,
    input  logic [WORD-1:0]  wb_data_i,
    output logic             v_o,
    input  logic             stall_i,
    output logic [WORD-1:0]  src_o,
    output logic [WORD-1:0]  dest_o,
    output logic [W_OPC-1:0] opc_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_rd_name_o,
    output logic [ADDR-1:0]  origaddr_o,
    output logic [15:0]      stall_cnt_o
);

    function automatic logic [NREG-1:0] onehot(input logic [W_RD-1:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [WORD-1:0] ext_imm(input logic [W_IMM-1:0] imm,
                                                 input logic sext);
        if (sext) begin
            return {{(WORD-W_IMM){imm[W_IMM-1]}}, imm};
        end else begin
            return {{(WORD-W_IMM){1'b0}}, imm};
        end
    endfunction

    logic [W_OPC-1:0] opc_s;
    logic             immf_s;
    logic [W_RD-1:0]  rd_s;
    logic [W_RD-1:0]  rs_s;
    logic [W_IMM-1:0] imm_s;
    logic             unused_inst_s;

    assign opc_s         = inst_i[WORD-1 -: W_OPC];
    assign immf_s        = inst_i[WORD-1-W_OPC];
    assign rd_s          = inst_i[WORD-2-W_OPC -: W_RD];
    assign rs_s          = inst_i[WORD-2-W_OPC-W_RD -: W_RD];
    assign imm_s         = inst_i[W_IMM-1:0];
    assign unused_inst_s = ^inst_i;

    assign rd_name_o = rd_s;
    assign rs_name_o = rs_s;

    logic [NREG-1:0] res_r;
    logic [NREG-1:0] wb_hit_s;
    logic [NREG-1:0] eff_res_s;
    logic [NREG-1:0] rel_s;
    logic [NREG-1:0] set_s;
    logic [NREG-1:0] res_next_s;
    logic            hazard_s;
    logic            adv_s;
    logic            issue_s;
    logic [WORD-1:0] src_s;
    logic [WORD-1:0] dest_s;

    // A writeback landing this cycle forwards, so it already lifts its reservation.
    assign wb_hit_s  = wb_v_i ? onehot(wb_name_i) : {NREG{1'b0}};
    assign eff_res_s = res_r & ~wb_hit_s;

    // Hazard detection; immediate instructions never look at rs.
    always_comb begin
        hazard_s = 1'b0;
        if (v_i) begin
            hazard_s = (~immf_s & eff_res_s[rs_s])
                     | ((RDSRC_MASK[opc_s] | WB_MASK[opc_s]) & eff_res_s[rd_s]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign adv_s   = ~(v_o & stall_i);
    assign issue_s = adv_s & v_i & ~hazard_s & ~flush_i & WB_MASK[opc_s];
    assign stall_o = (v_o & stall_i) | hazard_s;

    // Operand selection with writeback forwarding and immediate expansion.
    always_comb begin
        src_s  = rs_data_i;
        dest_s = rd_data_i;
        if (immf_s) begin
            src_s = ext_imm(imm_s, SEXT_MASK[opc_s]);
        end else if (wb_v_i && (wb_name_i == rs_s)) begin
            src_s = wb_data_i;
        end else begin
            src_s = rs_data_i;
        end
        if (wb_v_i && (wb_name_i == rd_s)) begin
            dest_s = wb_data_i;
        end else begin
            dest_s = rd_data_i;
        end
    end

    // A flushed writer never reaches writeback, so its reservation is returned here.
    assign rel_s      = (flush_i & v_o & wb_o) ? onehot(wb_rd_name_o) : {NREG{1'b0}};
    assign set_s      = issue_s ? onehot(rd_s) : {NREG{1'b0}};
    assign res_next_s = (res_r & ~(wb_hit_s | rel_s)) | set_s;

    // Output register towards EX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_o          <= 1'b0;
            src_o        <= {WORD{1'b0}};
            dest_o       <= {WORD{1'b0}};
            opc_o        <= {W_OPC{1'b0}};
            wb_o         <= 1'b0;
            wb_rd_name_o <= {W_RD{1'b0}};
            origaddr_o   <= {ADDR{1'b0}};
        end else if (flush_i) begin
            v_o <= 1'b0;
        end else if (adv_s) begin
            v_o          <= v_i & ~hazard_s;
            src_o        <= src_s;
            dest_o       <= dest_s;
            opc_o        <= opc_s;
            wb_o         <= WB_MASK[opc_s];
            wb_rd_name_o <= rd_s;
            origaddr_o   <= origaddr_i;
        end
    end

    // Reservation scoreboard and saturating hazard-stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_r       <= {NREG{1'b0}};
            stall_cnt_o <= 16'h0000;
        end else begin
            res_r <= res_next_s;
            if (hazard_s && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_idecode_sb.sv
// Directed bench for idecode_sb with a per-cycle reference model of the
// decode stage and scoreboard plus hand-computed spot checks.
module tb_idecode_sb;

    localparam logic [31:0] WBM = 32'h0000_000A;
    localparam logic [31:0] RDM = 32'h0000_0010;
    localparam logic [31:0] SXM = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst, v_i, stall_o, flush_i, wb_v_i, v_o, stall_i, wb_o;
    logic [31:0] inst_i, origaddr_i, rd_data_i, rs_data_i, wb_data_i;
    logic [31:0] src_o, dest_o, origaddr_o;
    logic [2:0]  rd_name_o, rs_name_o, wb_name_i, wb_rd_name_o;
    logic [4:0]  opc_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] rf [8];
    int checks = 0;
    int errors = 0;

    idecode_sb #(.WORD(32), .ADDR(32), .NREG(8), .W_OPC(5), .W_IMM(8),
                 .WB_MASK(WBM), .RDSRC_MASK(RDM), .SEXT_MASK(SXM)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .inst_i(inst_i),
        .origaddr_i(origaddr_i), .flush_i(flush_i), .rd_name_o(rd_name_o),
        .rs_name_o(rs_name_o), .rd_data_i(rd_data_i), .rs_data_i(rs_data_i),
        .wb_v_i(wb_v_i), .wb_name_i(wb_name_i), .wb_data_i(wb_data_i), .v_o(v_o),
        .stall_i(stall_i), .src_o(src_o), .dest_o(dest_o), .opc_o(opc_o),
        .wb_o(wb_o), .wb_rd_name_o(wb_rd_name_o), .origaddr_o(origaddr_o),
        .stall_cnt_o(stall_cnt_o));

    always #5 clk = ~clk;

    assign rd_data_i = rf[rd_name_o];
    assign rs_data_i = rf[rs_name_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(int opc, int immf, int rd, int rs, int imm);
        return 32'((opc << 27) | (immf << 26) | (rd << 23) | (rs << 20) | (imm & 255));
    endfunction

    // Reference model: opcode 1 and 3 write rd, 4 reads rd, 3 sign-extends.
    bit [7:0] m_res;
    bit       m_v, m_wb;
    int       m_opc, m_name, m_cnt;
    logic [31:0] m_src, m_dest, m_addr;

    function automatic bit m_writes(int o); return (o == 1) || (o == 3); endfunction
    function automatic bit m_readsrd(int o); return o == 4; endfunction
    function automatic bit m_sext(int o); return o == 3; endfunction
    function automatic int f_opc(); return int'((inst_i >> 27) & 31); endfunction
    function automatic int f_immf(); return int'((inst_i >> 26) & 1); endfunction
    function automatic int f_rd(); return int'((inst_i >> 23) & 7); endfunction
    function automatic int f_rs(); return int'((inst_i >> 20) & 7); endfunction

    function automatic bit m_reserved(int r);
        return m_res[r] && !(wb_v_i && (int'(wb_name_i) == r));
    endfunction

    function automatic bit m_haz();
        if (!v_i) return 1'b0;
        return ((f_immf() == 0) && m_reserved(f_rs()))
            || ((m_readsrd(f_opc()) || m_writes(f_opc())) && m_reserved(f_rd()));
    endfunction

    function automatic logic [31:0] m_fwd(int r);
        return (wb_v_i && (int'(wb_name_i) == r)) ? wb_data_i : rf[r];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_v = 0; m_wb = 0; m_opc = 0; m_name = 0; m_cnt = 0;
            m_src = 0; m_dest = 0; m_addr = 0; m_res = 0;
        end else begin
            bit haz;
            int rel, set, imm;
            haz = m_haz();
            rel = -1;
            set = -1;
            imm = int'(inst_i & 255);
            if (haz && m_cnt < 65535) m_cnt++;
            if (flush_i) begin
                if (m_v && m_wb) rel = m_name;
                m_v = 0;
            end else if (!(m_v && stall_i)) begin
                m_v    = v_i && !haz;
                m_opc  = f_opc();
                m_name = f_rd();
                m_addr = origaddr_i;
                m_wb   = m_writes(f_opc());
                if (f_immf() != 0)
                    m_src = (m_sext(f_opc()) && imm >= 128) ? (32'hFFFF_FF00 | 32'(imm)) : 32'(imm);
                else
                    m_src = m_fwd(f_rs());
                m_dest = m_fwd(f_rd());
                if (v_i && !haz && m_writes(f_opc())) set = f_rd();
            end
            if (wb_v_i) m_res[wb_name_i] = 1'b0;
            if (rel >= 0) m_res[rel] = 1'b0;
            if (set >= 0) m_res[set] = 1'b1;
        end
    end

    // Per-cycle comparison against the model, after inputs for the cycle settle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("m_v_o", 64'(v_o), 64'(m_v));
            chk("m_stall_o", 64'(stall_o), 64'((m_v && stall_i) || m_haz()));
            chk("m_stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
            chk("m_rd_name", 64'(rd_name_o), 64'(f_rd()));
            chk("m_rs_name", 64'(rs_name_o), 64'(f_rs()));
            if (m_v) begin
                chk("m_src", 64'(src_o), 64'(m_src));
                chk("m_dest", 64'(dest_o), 64'(m_dest));
                chk("m_opc", 64'(opc_o), 64'(m_opc));
                chk("m_wb", 64'(wb_o), 64'(m_wb));
                chk("m_wb_name", 64'(wb_rd_name_o), 64'(m_name));
                chk("m_addr", 64'(origaddr_o), 64'(m_addr));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wb(int name, logic [31:0] data);
        v_i = 0; wb_v_i = 1; wb_name_i = 3'(name); wb_data_i = data;
        tick();
        wb_v_i = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rst = 0; v_i = 1; inst_i = 32'hFFFF_FFFF; origaddr_i = 32'hA5A5_A5A5;
        flush_i = 0; wb_v_i = 0; wb_name_i = 0; wb_data_i = 0; stall_i = 0;
        tick();
        tick();
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_src", 64'(src_o), 64'd0);
        chk("rst_dest", 64'(dest_o), 64'd0);
        chk("rst_opc", 64'(opc_o), 64'd0);
        chk("rst_wb", 64'(wb_o), 64'd0);
        chk("rst_wb_name", 64'(wb_rd_name_o), 64'd0);
        chk("rst_addr", 64'(origaddr_o), 64'd0);
        chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);

        // First instruction after reset: writer of r3, immediate 5.
        rst = 1; inst_i = mk(1, 1, 3, 0, 5); origaddr_i = 32'h0000_0100;
        tick();
        chk("first_v_o", 64'(v_o), 64'd1);
        chk("first_name", 64'(wb_rd_name_o), 64'd3);
        chk("first_src", 64'(src_o), 64'd5);
        chk("first_addr", 64'(origaddr_o), 64'h100);

        // RAW on r3 until writeback forwards DEADBEEF.
        inst_i = mk(2, 0, 1, 3, 0); origaddr_i = 32'h0000_0104;
        for (int i = 0; i < 3; i++) begin
            #1 chk("raw_stall", 64'(stall_o), 64'd1);
            tick();
            chk("raw_bubble", 64'(v_o), 64'd0);
        end
        wb_v_i = 1; wb_name_i = 3'd3; wb_data_i = 32'hDEAD_BEEF;
        #1 chk("raw_release", 64'(stall_o), 64'd0);
        tick();
        chk("raw_fwd_src", 64'(src_o), 64'hDEAD_BEEF);
        chk("raw_v_o", 64'(v_o), 64'd1);
        chk("raw_cnt", 64'(stall_cnt_o), 64'd3);
        wb_v_i = 0;

        // Immediate path ignores a reserved rs.
        inst_i = mk(1, 1, 5, 0, 0);
        tick();
        inst_i = mk(3, 1, 6, 5, 8'hF0);
        #1 chk("imm_sext_stall", 64'(stall_o), 64'd0);
        tick();
        chk("imm_sext_src", 64'(src_o), 64'hFFFF_FFF0);
        inst_i = mk(1, 1, 7, 5, 8'hF0);
        #1 chk("imm_zext_stall", 64'(stall_o), 64'd0);
        tick();
        chk("imm_zext_src", 64'(src_o), 64'h0000_00F0);
        wb(5, 32'h5); wb(6, 32'h6); wb(7, 32'h7);

        // Backpressure: held IF writer of r2 must not reserve r2.
        v_i = 1; inst_i = mk(1, 1, 1, 0, 9);
        tick();
        stall_i = 1; inst_i = mk(1, 1, 2, 0, 3); origaddr_i = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_stall", 64'(stall_o), 64'd1);
            tick();
            chk("bp_v_o", 64'(v_o), 64'd1);
            chk("bp_name", 64'(wb_rd_name_o), 64'd1);
            chk("bp_src", 64'(src_o), 64'd9);
        end
        v_i = 0; stall_i = 0;
        tick();
        v_i = 1; inst_i = mk(2, 0, 0, 2, 0);
        #1 chk("bp_no_res", 64'(stall_o), 64'd0);
        tick();
        wb(1, 32'h1);

        // Flush releases r2 reserved by the killed writer.
        v_i = 1; inst_i = mk(1, 1, 2, 0, 1);
        tick();
        v_i = 0; flush_i = 1;
        tick();
        chk("flush_v_o", 64'(v_o), 64'd0);
        flush_i = 0; v_i = 1; inst_i = mk(2, 0, 0, 2, 0);
        #1 chk("flush_release", 64'(stall_o), 64'd0);
        tick();

        // Set/clear collision on r4: set wins.
        inst_i = mk(1, 1, 4, 0, 0);
        tick();
        wb_v_i = 1; wb_name_i = 3'd4; wb_data_i = 32'h44;
        #1 chk("coll_issue", 64'(stall_o), 64'd0);
        tick();
        wb_v_i = 0; inst_i = mk(2, 0, 0, 4, 0);
        #1 chk("coll_res", 64'(stall_o), 64'd1);
        tick();
        wb(4, 32'h4);

        // rd read as source by opcode 4.
        v_i = 1; inst_i = mk(1, 1, 3, 0, 0);
        tick();
        inst_i = mk(4, 1, 3, 0, 0);
        #1 chk("rdsrc_stall", 64'(stall_o), 64'd1);
        tick();
        wb(3, 32'h33);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
